// File: rtl/mem_stream_pkg.sv
// Shared types and sizing helpers for the memory stream reader.
package mem_stream_pkg;

   localparam int unsigned ADDR_W_DEF     = 16;
   localparam int unsigned DATA_W_DEF     = 16;
   localparam int unsigned FIFO_DEPTH_DEF = 4;
   localparam int unsigned FIFO_CNT_W     = $clog2(FIFO_DEPTH_DEF) + 1;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } state_e;

   // Count must represent 0..depth inclusive.
   function automatic int unsigned fifo_cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/mem_stream_reader_fifo.sv
// Small synchronous FIFO that absorbs RAM read latency; head is shown combinationally.
module stream_fifo
   import mem_stream_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                push,
   input  logic [DATA_W-1:0]                   push_data,
   input  logic                                pop,
   input  logic                                flush,
   output logic [DATA_W-1:0]                   head_data,
   output logic [fifo_cnt_w(FIFO_DEPTH)-1:0]   count,
   output logic                                empty,
   output logic                                full
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = fifo_cnt_w(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              do_pop;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(FIFO_DEPTH));
   assign count     = count_q;
   assign do_pop    = pop && !empty;
   assign head_data = empty ? '0 : mem[rd_ptr_q];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push && !flush) mem[wr_ptr_q] <= push_data;
   end

   push_not_full: assert property (@(posedge clock) disable iff (reset)
      (push && !flush) |-> !full);

endmodule

// File: rtl/mem_stream_reader.sv
// Streams a (base, length) block out of the sample RAM as a valid/ready word stream.
module mem_stream_reader
   import mem_stream_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rdaddress,
   input  logic [DATA_W-1:0] q,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int unsigned CNT_W = fifo_cnt_w(FIFO_DEPTH);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] remaining_q, remaining_d;
   logic [ADDR_W-1:0] rdaddr_q;
   logic              inflight_q;
   logic              done_q, done_d;

   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty, fifo_full;
   logic [CNT_W:0]    credit_used;
   logic              issue, push, pop, drain_exit;

   // A word in flight from the RAM counts against FIFO space.
   assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
   assign issue       = (state_q == StRun) && (remaining_q != '0) && !abort &&
                        (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
   assign push        = inflight_q && !abort;
   assign out_valid   = !fifo_empty;
   assign pop         = out_valid && out_ready;
   assign drain_exit  = !inflight_q &&
                        (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));

   assign rdaddress   = issue ? addr_q : rdaddr_q;
   assign busy        = (state_q != StIdle);
   assign done        = done_q;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      if (abort) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_d     = StRun;
                  addr_d      = base_addr;
                  remaining_d = length;
               end
            end
            StRun: begin
               if (issue) begin
                  addr_d      = addr_q + ADDR_W'(1);
                  remaining_d = remaining_q - ADDR_W'(1);
               end else if (remaining_q == '0) begin
                  state_d = StDrain;
               end
            end
            StDrain: begin
               if (drain_exit) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         remaining_q <= '0;
         rdaddr_q    <= '0;
         inflight_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         inflight_q  <= issue;
         done_q      <= done_d;
         if (issue) rdaddr_q <= addr_q;
      end
   end

   stream_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (q),
      .pop       (pop),
      .flush     (abort),
      .head_data (out_data),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   credit_bound: assert property (@(posedge clock) disable iff (reset)
      credit_used <= (CNT_W + 1)'(FIFO_DEPTH));

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader against a word = address + 0x1000 RAM model.
module tb_mem_stream_reader;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] base_addr;
   logic [15:0] length;
   logic        abort;
   logic        busy;
   logic        done;
   logic [15:0] rdaddress;
   logic [15:0] q;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] sb [$];
   bit          prev_stall = 1'b0;
   logic [15:0] prev_data  = '0;

   always #5 clock = ~clock;

   mem_stream_reader #(
      .ADDR_W     (16),
      .DATA_W     (16),
      .FIFO_DEPTH (4)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .rdaddress (rdaddress),
      .q         (q),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   function automatic logic [15:0] ram_word(input logic [15:0] a);
      return a + 16'h1000;
   endfunction

   always @(posedge clock) q <= ram_word(rdaddress);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every accepted word and checks stall stability.
   always @(negedge clock) begin
      if (reset || abort) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid_held", {31'd0, out_valid}, 32'd1);
            check("stall_data_held", {16'd0, out_data}, {16'd0, prev_data});
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_word: got %0h, expected no word at %0t", out_data, $time);
            end else begin
               check("stream_word", {16'd0, out_data}, {16'd0, sb.pop_front()});
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating.
   task automatic run_job(input logic [15:0] b, input logic [15:0] l, input int mode,
                          input int exp_done, input int exp_first, input int abort_after,
                          input int poke);
      int xfers;
      int first_v;
      int done_k;
      bit abort_sent;
      bit finished;
      xfers = 0; first_v = 0; done_k = 0; abort_sent = 0; finished = 0;
      @(posedge clock); #1;
      start = 1'b1; base_addr = b; length = l;
      @(posedge clock); #1;
      start = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
         start = (k == poke);
         if (k == poke) begin
            base_addr = 16'h0500;
            length    = 16'h0009;
         end
         if (abort_after != 0 && xfers == abort_after && !abort_sent) begin
            out_ready  = 1'b0;
            abort      = 1'b1;
            abort_sent = 1'b1;
         end else begin
            abort = 1'b0;
         end
         @(negedge clock);
         if (k == 1) check("busy_after_start", {31'd0, busy}, 32'd1);
         if (abort_sent && !abort) begin
            check("abort_busy_low", {31'd0, busy}, 32'd0);
            check("abort_valid_low", {31'd0, out_valid}, 32'd0);
            check("abort_no_done", {31'd0, done}, 32'd0);
            finished = 1'b1;
         end
         if (out_valid && first_v == 0) first_v = k;
         if (out_valid && out_ready) xfers++;
         if (done && !finished) done_k = k;
         if (finished || done_k != 0) break;
         @(posedge clock); #1;
      end
      start = 1'b0;
      abort = 1'b0;
      if (abort_after != 0) begin
         check("abort_reached", {31'd0, finished}, 32'd1);
         out_ready = 1'b1;
         for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check("post_abort_idle_done", {31'd0, done}, 32'd0);
            check("post_abort_idle_busy", {31'd0, busy}, 32'd0);
         end
      end else begin
         if (done_k == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected done within 300 cycles");
         end else begin
            check("busy_low_with_done", {31'd0, busy}, 32'd0);
            if (exp_done != 0) check("done_cycle", done_k, exp_done);
            if (exp_first != 0) check("first_valid_cycle", first_v, exp_first);
            check("all_words_delivered", sb.size(), 0);
            @(negedge clock);
            check("done_one_cycle", {31'd0, done}, 32'd0);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected finish before 500us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; abort = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_valid", {31'd0, out_valid}, 32'd0);
      check("reset_data", {16'd0, out_data}, 32'd0);
      check("reset_rdaddress", {16'd0, rdaddress}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Basic job, ready high.
      sb.push_back(16'h1010); sb.push_back(16'h1011);
      sb.push_back(16'h1012); sb.push_back(16'h1013);
      run_job(16'h0010, 16'd4, 0, 7, 3, 0, 0);

      // Same job under backpressure.
      sb.push_back(16'h1010); sb.push_back(16'h1011);
      sb.push_back(16'h1012); sb.push_back(16'h1013);
      run_job(16'h0010, 16'd4, 1, 0, 3, 0, 0);

      // Address wrap.
      sb.push_back(16'h0FFE); sb.push_back(16'h0FFF);
      sb.push_back(16'h1000); sb.push_back(16'h1001);
      run_job(16'hFFFE, 16'd4, 0, 7, 3, 0, 0);

      // Zero-length job.
      run_job(16'h0040, 16'd0, 0, 3, 0, 0, 0);

      // Abort after five transfers, then a short job.
      sb.push_back(16'h1200); sb.push_back(16'h1201); sb.push_back(16'h1202);
      sb.push_back(16'h1203); sb.push_back(16'h1204);
      run_job(16'h0200, 16'd16, 0, 0, 0, 5, 0);
      check("abort_sb_empty", sb.size(), 0);
      sb.push_back(16'h1100); sb.push_back(16'h1101);
      run_job(16'h0100, 16'd2, 0, 5, 3, 0, 0);

      // Asynchronous reset mid-job.
      for (int i = 0; i < 8; i++) sb.push_back(16'h1300 + 16'(i));
      @(posedge clock); #1;
      start = 1'b1; base_addr = 16'h0300; length = 16'd8; out_ready = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (4) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("async_reset_busy", {31'd0, busy}, 32'd0);
      check("async_reset_done", {31'd0, done}, 32'd0);
      check("async_reset_valid", {31'd0, out_valid}, 32'd0);
      check("async_reset_data", {16'd0, out_data}, 32'd0);
      check("async_reset_rdaddress", {16'd0, rdaddress}, 32'd0);
      sb.delete();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      repeat (3) begin
         @(negedge clock);
         check("post_reset_no_done", {31'd0, done}, 32'd0);
      end

      // Start while busy is ignored.
      sb.push_back(16'h1010); sb.push_back(16'h1011);
      sb.push_back(16'h1012); sb.push_back(16'h1013);
      run_job(16'h0010, 16'd4, 0, 7, 3, 0, 2);
      repeat (4) @(negedge clock);
      check("final_idle_busy", {31'd0, busy}, 32'd0);
      check("final_idle_valid", {31'd0, out_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
